ecc_scrub_controller: RTL and testbench

- Front-end controller sitting directly upstream of the SECDED-protected memory wrapper. It drives that wrapper's data/addr/wr_en inputs and consumes its decoded data and single/double error flags.
- Multiplexes a host read/write port with a background scrub engine. The scrub engine walks every address, rewrites corrected words so single-bit errors do not accumulate, and logs uncorrectable words.

---
 rtl/ecc_scrub_controller.sv | 118 +++++++++++
 tb/tb_ecc_scrub_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_controller.sv
// ecc_scrub_controller: host/scrub arbiter in front of a SECDED memory wrapper
module ecc_scrub_controller #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int RD_LAT         = 1,
  parameter int SCRUB_INTERVAL = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_sec,
  output logic              host_ded,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_sec,
  input  logic              mem_ded,
  input  logic              scrub_en,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_sticky,
  output logic [ADDR_W-1:0] last_ded_addr,
  output logic              pass_done
);
  localparam int LW = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;
  localparam int IW = $clog2(SCRUB_INTERVAL);
  typedef enum logic [2:0] {IDLE, HOST_WR, HOST_RD, SCRUB_RD, SCRUB_WB} state_t;
  state_t state, state_n;
  logic [LW-1:0] lat_cnt;
  logic [IW-1:0] icnt;
  logic [ADDR_W-1:0] ptr;
  logic idle, rd_done, expire, accept, scrub_go, sec_hit, sec_inc, ded_inc, ptr_step;
  assign idle       = state == IDLE;
  assign host_ready = idle;
  assign rd_done    = lat_cnt == LW'(RD_LAT);
  assign expire     = icnt == IW'(SCRUB_INTERVAL - 1);
  assign accept     = idle && host_req;
  assign scrub_go   = idle && !host_req && scrub_en && expire;
  // a word flagged both ways is treated as uncorrectable and never written back
  assign sec_hit    = mem_sec && !mem_ded;
  assign sec_inc    = state == SCRUB_RD && rd_done && sec_hit;
  assign ded_inc    = state == SCRUB_RD && rd_done && mem_ded;
  assign ptr_step   = (state == SCRUB_RD && rd_done && !sec_hit) || state == SCRUB_WB;
  // next-state selection; host wins over a scrub start in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = host_req ? (host_we ? HOST_WR : HOST_RD) : scrub_go ? SCRUB_RD : IDLE;
      HOST_RD:  state_n = rd_done ? IDLE : HOST_RD;
      SCRUB_RD: state_n = rd_done ? (sec_hit ? SCRUB_WB : IDLE) : SCRUB_RD;
      default:  state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end
  // registered memory control, host read capture, scrub bookkeeping and error log
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt       <= '0;
      icnt          <= '0;
      ptr           <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wr_en     <= 1'b0;
      host_rvalid   <= 1'b0;
      host_rdata    <= '0;
      host_sec      <= 1'b0;
      host_ded      <= 1'b0;
      sec_count     <= '0;
      ded_count     <= '0;
      ded_sticky    <= 1'b0;
      last_ded_addr <= '0;
      pass_done     <= 1'b0;
    end else begin
      lat_cnt   <= ((state == HOST_RD || state == SCRUB_RD) && !rd_done) ? lat_cnt + 1'b1 : '0;
      icnt      <= (!scrub_en || (idle && expire)) ? '0 : (idle && !host_req) ? icnt + 1'b1 : icnt;
      mem_wr_en <= state_n == HOST_WR || state_n == SCRUB_WB;
      if (accept) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else if (scrub_go) mem_addr <= ptr;
      if (sec_inc) mem_wdata <= mem_rdata;
      host_rvalid <= state == HOST_RD && rd_done;
      if (state == HOST_RD && rd_done) begin
        host_rdata <= mem_rdata;
        host_sec   <= mem_sec;
        host_ded   <= mem_ded;
      end
      ptr       <= ptr_step ? ptr + 1'b1 : ptr;
      pass_done <= ptr_step && &ptr;
      if (err_clr) begin
        sec_count     <= '0;
        ded_count     <= '0;
        ded_sticky    <= 1'b0;
        last_ded_addr <= '0;
      end else begin
        if (sec_inc && !(&sec_count)) sec_count <= sec_count + 1'b1;
        if (ded_inc) begin
          ded_count     <= &ded_count ? ded_count : ded_count + 1'b1;
          ded_sticky    <= 1'b1;
          last_ded_addr <= ptr;
        end
      end
    end
  end
endmodule

// File: tb/tb_ecc_scrub_controller.sv
// tb_ecc_scrub_controller: directed checks of host path, scrub engine and error log
module tb_ecc_scrub_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ready, host_rvalid, host_sec, host_ded;
  logic [7:0] host_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr, last_ded_addr;
  logic       mem_wr_en, mem_sec, mem_ded, pass_done, ded_sticky;
  logic       scrub_en = 1'b0, err_clr = 1'b0;
  logic [7:0] sec_count, ded_count;
  logic       f_sec = 1'b0, f_ded = 1'b0, ovr = 1'b0;
  logic [7:0] ovr_data = '0;
  logic [7:0] mem [16];
  logic [7:0] rd_q = '0;
  int tests = 0, fails = 0;

  ecc_scrub_controller #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .SCRUB_INTERVAL(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_sec(host_sec), .host_ded(host_ded), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .mem_sec(mem_sec),
    .mem_ded(mem_ded), .scrub_en(scrub_en), .err_clr(err_clr), .sec_count(sec_count),
    .ded_count(ded_count), .ded_sticky(ded_sticky), .last_ded_addr(last_ded_addr),
    .pass_done(pass_done));

  always #5 clk = ~clk;

  // wrapper stand-in: one-cycle registered read, error flags and data injectable
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
  end
  assign mem_rdata = ovr ? ovr_data : rd_q;
  assign mem_sec   = f_sec;
  assign mem_ded   = f_ded;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scrub_op(output logic [3:0] a, output int wr, output logic pd);
    int n;
    n = 0; wr = 0; a = '0; pd = 1'b0;
    while (host_ready && n < 30) begin tick(); n++; end
    if (host_ready) begin
      tests++; fails++;
      $error("FAIL scrub_start: observed no start expected start within 30 cycles");
    end
    a = mem_addr;
    n = 0;
    while (!host_ready && n < 30) begin
      if (mem_wr_en) wr++;
      tick(); n++;
    end
    if (!host_ready) begin
      tests++; fails++;
      $error("FAIL scrub_end: observed busy expected idle within 30 cycles");
    end
    pd = pass_done;
  endtask

  initial begin
    logic [3:0] a;
    int wr, n;
    logic pd, seen_low;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tick(); tick();
    check("rst_ready", host_ready, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rvalid", host_rvalid, 0);
    check("rst_counts", {sec_count, ded_count, ded_sticky, pass_done}, 0);
    rst = 1'b1;
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd3; host_wdata = 8'hA5;
    tick();
    host_req = 1'b0;
    check("wr_en_n1", mem_wr_en, 1);
    check("wr_addr", mem_addr, 3);
    check("wr_data", mem_wdata, 8'hA5);
    check("wr_busy", host_ready, 0);
    tick();
    check("wr_en_n2", mem_wr_en, 0);
    check("wr_ready_n2", host_ready, 1);
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
    tick();
    host_req = 1'b0;
    check("rd_addr", mem_addr, 3);
    check("rd_rvalid_n1", host_rvalid, 0);
    tick();
    check("rd_rvalid_n2", host_rvalid, 0);
    tick();
    check("rd_rvalid_n3", host_rvalid, 1);
    check("rd_data", host_rdata, 8'hA5);
    check("rd_flags", {host_sec, host_ded}, 0);
    check("rd_no_wr", mem_wr_en, 0);
    tick();
    check("rd_rvalid_n4", host_rvalid, 0);
    check("rd_data_hold", host_rdata, 8'hA5);
    scrub_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      scrub_op(a, wr, pd);
      check("pass_addr", a, i);
      check("pass_done", pd, i == 15);
    end
    check("pass_no_wr", wr, 0);
    scrub_op(a, wr, pd);
    check("wrap_addr", a, 0);
    check("wrap_no_pd", pd, 0);
    for (int i = 1; i < 5; i++) scrub_op(a, wr, pd);
    f_sec = 1'b1; ovr = 1'b1; ovr_data = 8'h3C;
    scrub_op(a, wr, pd);
    f_sec = 1'b0; ovr = 1'b0;
    check("sec_addr", a, 5);
    check("sec_wb_cycles", wr, 1);
    check("sec_mem5", mem[5], 8'h3C);
    check("sec_count1", sec_count, 1);
    check("sec_sticky0", ded_sticky, 0);
    for (int i = 6; i < 9; i++) scrub_op(a, wr, pd);
    f_ded = 1'b1;
    scrub_op(a, wr, pd);
    f_ded = 1'b0;
    check("ded_addr", a, 9);
    check("ded_no_wr", wr, 0);
    check("ded_count1", ded_count, 1);
    check("ded_sticky1", ded_sticky, 1);
    check("ded_last", last_ded_addr, 9);
    check("ded_sec_keep", sec_count, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_all", {sec_count, ded_count, ded_sticky, last_ded_addr}, 0);
    tick(); tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
    check("prio_ready", host_ready, 1);
    tick();
    host_req = 1'b0;
    check("prio_host_addr", mem_addr, 2);
    tick(); tick();
    check("prio_rvalid", host_rvalid, 1);
    check("prio_rdata", host_rdata, 0);
    seen_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!host_ready) seen_low = 1'b1;
      tick();
    end
    check("prio_fresh_interval", seen_low, 0);
    check("prio_scrub_start", host_ready, 0);
    check("prio_scrub_addr", mem_addr, 10);
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h5A;
    tick();
    check("busy_ready", host_ready, 0);
    tick();
    check("busy_served", host_ready, 1);
    tick();
    host_req = 1'b0;
    check("busy_wr_en", mem_wr_en, 1);
    check("busy_wr_addr", mem_addr, 7);
    check("busy_wr_data", mem_wdata, 8'h5A);
    tick();
    f_sec = 1'b1;
    for (int i = 0; i < 300; i++) scrub_op(a, wr, pd);
    check("sat_sec", sec_count, 255);
    check("sat_ded", ded_count, 0);
    n = 0;
    while (!mem_wr_en && n < 40) begin tick(); n++; end
    check("mid_wb_reached", mem_wr_en, 1);
    rst = 1'b0;
    #1;
    check("rst_async_wr_en", mem_wr_en, 0);
    check("rst_async_sec", sec_count, 0);
    check("rst_async_ready", host_ready, 1);
    f_sec = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (host_ready && n < 30) begin tick(); n++; end
    check("en_off_started", host_ready, 0);
    check("en_off_addr", mem_addr, 0);
    scrub_en = 1'b0;
    n = 0;
    while (!host_ready && n < 30) begin tick(); n++; end
    check("en_off_completes", host_ready, 1);
    seen_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!host_ready) seen_low = 1'b1;
    end
    check("en_off_no_restart", seen_low, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
